// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry valid/ready pipeline stage with a skid register.
// o_valid and o_ready come from registered state only, so neither handshake
// input has a combinational path to the opposite handshake output. Control
// bits are zeroed on bubbles and on flush. The payload is never reset.
// A saturating counter records the cycles in which downstream back-pressured
// a valid entry.
module pipe_stage_skid #(
   parameter int DATA_WIDTH = 32,
   parameter int NB_CTRL    = 8,
   parameter int NB_CNT     = 16
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [NB_CTRL-1:0]    i_ctrl,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [NB_CTRL-1:0]    o_ctrl,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [NB_CNT-1:0]     o_stall_cnt
);

   // Occupancy: ST_ONE means main is valid; ST_FULL means main and skid are valid.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]            state_p0;
   logic [1:0]            state_nxt;
   logic                  vld_p0;
   logic [NB_CTRL-1:0]    main_ctrl_p0;
   logic [NB_CTRL-1:0]    main_ctrl_nxt;
   logic [NB_CTRL-1:0]    skid_ctrl_p0;
   logic [DATA_WIDTH-1:0] main_data_p0;
   logic [DATA_WIDTH-1:0] skid_data_p0;
   logic [NB_CNT-1:0]     stall_cnt_p0;

   logic accept;
   logic take;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   // Count up by one and stick at the all-ones value instead of wrapping.
   function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
      logic [NB_CNT-1:0] r;
      if (&v) r = v;
      else    r = v + 1'b1;
      return r;
   endfunction

   // Handshake outputs depend only on registered state (and reset for ready).
   assign vld_p0      = (state_p0 != ST_EMPTY);
   assign o_valid     = vld_p0;
   assign o_ready     = (state_p0 != ST_FULL) & ~i_rst;
   assign accept      = i_valid & o_ready;
   assign take        = vld_p0 & i_ready;
   assign o_ctrl      = main_ctrl_p0;
   assign o_data      = main_data_p0;
   assign o_stall_cnt = stall_cnt_p0;

   // Next-state and register-load decisions. Flush overrides every transition
   // and suppresses all loads, which discards any same-cycle accept.
   always_comb begin
      state_nxt      = state_p0;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_p0)
         ST_EMPTY: begin
            if (accept) begin
               load_main_in = 1'b1;
               state_nxt    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && take) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nxt = ST_FULL;
            end else if (take) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (take) begin
               load_main_skid = 1'b1;
               state_nxt      = ST_ONE;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      if (i_flush) begin
         state_nxt      = ST_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // Control bits follow whichever entry lands in main; they are forced to
   // zero whenever the stage is about to be empty so bubbles carry no control.
   always_comb begin
      main_ctrl_nxt = main_ctrl_p0;
      if (load_main_in)   main_ctrl_nxt = i_ctrl;
      if (load_main_skid) main_ctrl_nxt = skid_ctrl_p0;
      if (state_nxt == ST_EMPTY) main_ctrl_nxt = '0;
   end

   // ---- stage p0 boundary: control state (reset applies here only) ----
   // Occupancy and main control bits; reset beats flush, flush beats handshakes.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_p0     <= ST_EMPTY;
         main_ctrl_p0 <= '0;
      end else begin
         state_p0     <= state_nxt;
         main_ctrl_p0 <= main_ctrl_nxt;
      end
   end

   // Payload and skid storage; not reset, contents only matter when occupied.
   always_ff @(posedge clk) begin
      if (load_main_in) begin
         main_data_p0 <= i_data;
      end else if (load_main_skid) begin
         main_data_p0 <= skid_data_p0;
      end
      if (load_skid) begin
         skid_data_p0 <= i_data;
         skid_ctrl_p0 <= i_ctrl;
      end
   end

   // Back-pressure counter: valid entry held while downstream refuses it.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         stall_cnt_p0 <= '0;
      end else if (vld_p0 && !i_ready) begin
         stall_cnt_p0 <= sat_inc(stall_cnt_p0);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: single pass, stall into FULL, flush,
// back-to-back streaming, randomized streaming with a scoreboard, counter
// saturation on a narrow-counter instance, and reset while FULL.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_flush;
   logic        i_valid;
   logic        i_ready;
   logic [7:0]  i_ctrl;
   logic [31:0] i_data;

   logic        o_ready;
   logic        o_valid;
   logic [7:0]  o_ctrl;
   logic [31:0] o_data;
   logic [15:0] o_stall_cnt;

   logic        n_ready;
   logic        n_valid;
   logic [7:0]  n_ctrl;
   logic [31:0] n_data;
   logic [3:0]  n_stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_WIDTH(32), .NB_CTRL(8), .NB_CNT(16)) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_flush     (i_flush),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_ctrl      (i_ctrl),
      .i_data      (i_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_ctrl      (o_ctrl),
      .o_data      (o_data),
      .o_stall_cnt (o_stall_cnt)
   );

   pipe_stage_skid #(.DATA_WIDTH(32), .NB_CTRL(8), .NB_CNT(4)) dut_n4 (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_flush     (i_flush),
      .i_valid     (i_valid),
      .o_ready     (n_ready),
      .i_ctrl      (i_ctrl),
      .i_data      (i_data),
      .o_valid     (n_valid),
      .i_ready     (i_ready),
      .o_ctrl      (n_ctrl),
      .o_data      (n_data),
      .o_stall_cnt (n_stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d);
      i_valid = v;
      i_ctrl  = c;
      i_data  = d;
   endtask

   logic [31:0] q[$];
   logic [31:0] exp_d;
   int          n_in;
   int          n_out;
   int          cyc;

   initial begin
      i_rst   = 1'b1;
      i_flush = 1'b0;
      i_ready = 1'b0;
      drive(1'b0, 8'h00, 32'h0);

      // Reset state
      tick();
      tick();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ctrl", 32'(o_ctrl), 32'h00);
      chk("rst_cnt", 32'(o_stall_cnt), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      i_rst = 1'b0;
      #1;
      chk("rst_release_ready", 32'(o_ready), 32'd1);

      // Single pass
      i_ready = 1'b1;
      drive(1'b1, 8'h81, 32'h0000_1234);
      tick();
      chk("single_valid", 32'(o_valid), 32'd1);
      chk("single_ctrl", 32'(o_ctrl), 32'h81);
      chk("single_data", o_data, 32'h1234);
      drive(1'b0, 8'h00, 32'h0);
      tick();
      chk("single_drain_valid", 32'(o_valid), 32'd0);
      chk("single_drain_ctrl", 32'(o_ctrl), 32'h00);
      chk("single_cnt", 32'(o_stall_cnt), 32'd0);

      // Stall into FULL with A then B
      i_ready = 1'b0;
      drive(1'b1, 8'h01, 32'h1);
      tick();
      chk("stallA_valid", 32'(o_valid), 32'd1);
      chk("stallA_ready", 32'(o_ready), 32'd1);
      drive(1'b1, 8'h02, 32'h2);
      tick();
      chk("full_ready", 32'(o_ready), 32'd0);
      chk("full_data", o_data, 32'h1);
      chk("full_ctrl", 32'(o_ctrl), 32'h01);
      chk("full_cnt1", 32'(o_stall_cnt), 32'd1);
      drive(1'b0, 8'h00, 32'h0);
      tick();
      chk("full_cnt2", 32'(o_stall_cnt), 32'd2);
      chk("full_hold_data", o_data, 32'h1);
      i_ready = 1'b1;
      tick();
      chk("drainB_valid", 32'(o_valid), 32'd1);
      chk("drainB_data", o_data, 32'h2);
      chk("drainB_ctrl", 32'(o_ctrl), 32'h02);
      chk("drainB_ready", 32'(o_ready), 32'd1);
      chk("drainB_cnt", 32'(o_stall_cnt), 32'd2);
      tick();
      chk("drained_valid", 32'(o_valid), 32'd0);
      chk("drained_ctrl", 32'(o_ctrl), 32'h00);

      // Flush while FULL with a same-cycle offered entry
      i_ready = 1'b0;
      drive(1'b1, 8'h03, 32'h3);
      tick();
      drive(1'b1, 8'h04, 32'h4);
      tick();
      chk("preflush_ready", 32'(o_ready), 32'd0);
      i_flush = 1'b1;
      drive(1'b1, 8'h05, 32'h5);
      tick();
      chk("flush_valid", 32'(o_valid), 32'd0);
      chk("flush_ctrl", 32'(o_ctrl), 32'h00);
      chk("flush_ready", 32'(o_ready), 32'd1);
      chk("flush_cnt", 32'(o_stall_cnt), 32'd4);
      // Flush from EMPTY discards the accepted entry as well
      drive(1'b1, 8'h06, 32'h6);
      tick();
      chk("flush_accept_valid", 32'(o_valid), 32'd0);
      i_flush = 1'b0;
      drive(1'b0, 8'h00, 32'h0);
      i_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("flush_nothing_out", 32'(o_valid), 32'd0);
      end
      chk("flush_cnt_after", 32'(o_stall_cnt), 32'd4);

      // Back-to-back: one entry per cycle, o_ready never drops
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 8'h40 + 8'(k), 32'h100 + 32'(k));
         tick();
         chk("b2b_valid", 32'(o_valid), 32'd1);
         chk("b2b_data", o_data, 32'h100 + 32'(k));
         chk("b2b_ready", 32'(o_ready), 32'd1);
      end
      drive(1'b0, 8'h00, 32'h0);
      tick();
      chk("b2b_end_valid", 32'(o_valid), 32'd0);

      // Randomized streaming of 100 words against a FIFO scoreboard
      n_in  = 0;
      n_out = 0;
      cyc   = 0;
      while (n_out < 100 && cyc < 3000) begin
         i_ready = 1'($urandom_range(0, 1));
         if (n_in < 100 && $urandom_range(0, 3) != 0)
            drive(1'b1, 8'h80 | 8'(n_in), 32'(n_in));
         else
            drive(1'b0, 8'h00, 32'h0);
         if (o_valid && i_ready) begin
            if (q.size() == 0) begin
               chk("stream_spurious", o_data, 32'hFFFF_FFFF);
            end else begin
               exp_d = q.pop_front();
               chk("stream_data", o_data, exp_d);
               chk("stream_ctrl", 32'(o_ctrl), 32'(8'h80 | exp_d[7:0]));
            end
            n_out++;
         end
         if (i_valid && o_ready) begin
            q.push_back(i_data);
            n_in++;
         end
         tick();
         cyc++;
      end
      chk("stream_out_count", 32'(n_out), 32'd100);
      chk("stream_in_count", 32'(n_in), 32'd100);
      chk("stream_leftover", 32'(q.size()), 32'd0);
      i_ready = 1'b0;
      drive(1'b0, 8'h00, 32'h0);

      // Counter saturation: 4-bit instance sticks at 0xF, 16-bit keeps counting
      i_rst = 1'b1;
      tick();
      chk("sat_rst_cnt16", 32'(o_stall_cnt), 32'd0);
      chk("sat_rst_cnt4", 32'(n_stall_cnt), 32'd0);
      i_rst = 1'b0;
      drive(1'b1, 8'h22, 32'h22);
      tick();
      drive(1'b0, 8'h00, 32'h0);
      for (int k = 0; k < 15; k++) tick();
      chk("sat_cnt4_at15", 32'(n_stall_cnt), 32'hF);
      for (int k = 0; k < 5; k++) tick();
      chk("sat_cnt4_held", 32'(n_stall_cnt), 32'hF);
      chk("sat_cnt16", 32'(o_stall_cnt), 32'd20);
      chk("sat_data", o_data, 32'h22);

      // Reset while FULL
      drive(1'b1, 8'h33, 32'h33);
      tick();
      chk("rstfull_ready", 32'(o_ready), 32'd0);
      i_rst = 1'b1;
      tick();
      chk("rstfull_valid", 32'(o_valid), 32'd0);
      chk("rstfull_ctrl", 32'(o_ctrl), 32'h00);
      chk("rstfull_cnt", 32'(o_stall_cnt), 32'd0);
      chk("rstfull_ready_rst", 32'(o_ready), 32'd0);
      tick();
      chk("rstfull_valid2", 32'(o_valid), 32'd0);
      i_rst   = 1'b0;
      i_ready = 1'b1;
      drive(1'b1, 8'h11, 32'hABC);
      #1;
      chk("resume_ready", 32'(o_ready), 32'd1);
      tick();
      chk("resume_valid", 32'(o_valid), 32'd1);
      chk("resume_data", o_data, 32'hABC);
      chk("resume_ctrl", 32'(o_ctrl), 32'h11);
      drive(1'b0, 8'h00, 32'h0);
      tick();
      chk("resume_drain", 32'(o_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
